// File: rtl/ps2_receptor.sv
// ps2_receptor
//   PS/2 keyboard serial receiver. Synchronizes the raw ps2c/ps2d lines,
//   debounces ps2c, detects its falling edges and assembles 11-bit frames
//   (start, 8 data bits LSB first, odd parity, stop). A valid frame updates
//   byte_dato and pulses scan_done_tick for one cycle. A parity error, a stop
//   error or a stalled frame pulses frame_err instead.
//
// Ports
//   clk_Nexys      in   system clock (100 MHz), rising edge
//   Reset          in   asynchronous, active-high reset
//   ps2c           in   raw PS/2 clock (asynchronous)
//   ps2d           in   raw PS/2 data  (asynchronous)
//   rx_en          in   allows a new frame to start
//   byte_dato      out  last valid received byte (registered)
//   scan_done_tick out  one-cycle pulse, byte_dato is new
//   frame_err      out  one-cycle pulse on parity/stop error or timeout
//   busy           out  high while a frame is in progress
module ps2_receptor #(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 200000
) (
    input  logic       clk_Nexys,
    input  logic       Reset,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       rx_en,
    output logic [7:0] byte_dato,
    output logic       scan_done_tick,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TOUT_ONE  = TW'(1);

    typedef enum logic [1:0] {
        idle,
        dps,
        load
    } state_t;

    // input conditioning
    logic                  c_meta, c_sync, d_meta, d_sync;
    logic [FILTER_LEN-1:0] filt_reg;
    logic                  filt_val, filt_next;
    logic                  fall_edge;

    // receiver state
    state_t        state_reg, state_next;
    logic [9:0]    b_reg, b_next, shift_in;
    logic [3:0]    n_reg, n_next;
    logic [TW-1:0] tout_reg, tout_next;
    logic [7:0]    byte_next;
    logic          tick_next, err_next;

    always_ff @(posedge clk_Nexys or posedge Reset) begin
        if (Reset) begin
            c_meta   <= 1'b1;
            c_sync   <= 1'b1;
            d_meta   <= 1'b1;
            d_sync   <= 1'b1;
            filt_reg <= '1;
            filt_val <= 1'b1;
        end else begin
            c_meta   <= ps2c;
            c_sync   <= c_meta;
            d_meta   <= ps2d;
            d_sync   <= d_meta;
            filt_reg <= {c_sync, filt_reg[FILTER_LEN-1:1]};
            filt_val <= filt_next;
        end
    end

    // Filtered level only moves once the whole window agrees.
    always_comb begin
        filt_next = filt_val;
        if (&filt_reg) begin
            filt_next = 1'b1;
        end else if (~|filt_reg) begin
            filt_next = 1'b0;
        end
    end

    assign fall_edge = filt_val & ~filt_next;

    always_ff @(posedge clk_Nexys or posedge Reset) begin
        if (Reset) begin
            state_reg      <= idle;
            b_reg          <= '0;
            n_reg          <= '0;
            tout_reg       <= '0;
            byte_dato      <= '0;
            scan_done_tick <= 1'b0;
            frame_err      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            b_reg          <= b_next;
            n_reg          <= n_next;
            tout_reg       <= tout_next;
            byte_dato      <= byte_next;
            scan_done_tick <= tick_next;
            frame_err      <= err_next;
        end
    end

    // The frame is judged on the stop-bit edge from the incoming shift value,
    // so byte_dato and the pulse register together and appear during load.
    always_comb begin
        state_next = state_reg;
        b_next     = b_reg;
        n_next     = n_reg;
        tout_next  = tout_reg;
        byte_next  = byte_dato;
        tick_next  = 1'b0;
        err_next   = 1'b0;
        shift_in   = {d_sync, b_reg[9:1]};

        case (state_reg)
            idle: begin
                tout_next = '0;
                if (fall_edge && rx_en && !d_sync) begin
                    state_next = dps;
                    n_next     = '0;
                end
            end
            dps: begin
                if (fall_edge) begin
                    b_next    = shift_in;
                    n_next    = n_reg + 4'd1;
                    tout_next = '0;
                    if (n_reg == 4'd9) begin
                        state_next = load;
                        if (shift_in[9] && (^shift_in[8:0])) begin
                            byte_next = shift_in[7:0];
                            tick_next = 1'b1;
                        end else begin
                            err_next = 1'b1;
                        end
                    end
                end else if (tout_reg == TOUT_LAST) begin
                    state_next = idle;
                    err_next   = 1'b1;
                end else begin
                    tout_next = tout_reg + TOUT_ONE;
                end
            end
            load: begin
                state_next = idle;
                tout_next  = '0;
            end
            default: begin
                state_next = idle;
            end
        endcase
    end

    assign busy = (state_reg != idle);

endmodule

// File: tb/tb_ps2_receptor.sv
// tb_ps2_receptor
//   Drives PS/2 frames (directed and random) into ps2_receptor. A frame-level
//   model predicts, for each frame, whether it yields a byte or an error and
//   on which clock cycle; a compare process checks every cycle.
module tb_ps2_receptor;

    localparam int FLEN = 8;
    localparam int TO   = 1000;
    localparam int LAT  = 2 + FLEN + 1;   // raw ps2c fall -> pulse visible

    logic       clk_Nexys = 1'b0;
    logic       Reset     = 1'b1;
    logic       ps2c      = 1'b1;
    logic       ps2d      = 1'b1;
    logic       rx_en     = 1'b1;
    logic [7:0] byte_dato;
    logic       scan_done_tick;
    logic       frame_err;
    logic       busy;

    ps2_receptor #(
        .FILTER_LEN (FLEN),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk_Nexys     (clk_Nexys),
        .Reset         (Reset),
        .ps2c          (ps2c),
        .ps2d          (ps2d),
        .rx_en         (rx_en),
        .byte_dato     (byte_dato),
        .scan_done_tick(scan_done_tick),
        .frame_err     (frame_err),
        .busy          (busy)
    );

    always #5 clk_Nexys = ~clk_Nexys;

    typedef struct {
        bit         is_err;
        int         cyc;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc   = 0;
    logic [7:0] model_byte = 8'h00;
    int         bs = 1;          // expected busy window [bs, be]
    int         be = 0;

    always @(posedge clk_Nexys) cyc <= cyc + 1;

    // per-cycle comparison against the model
    always @(negedge clk_Nexys) begin
        ev_t ev;
        bit  exp_busy;
        if (Reset) begin
            model_byte = 8'h00;
            tests++;
            if (byte_dato !== 8'h00 || scan_done_tick !== 1'b0 ||
                frame_err !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL reset_outputs cyc=%0d got byte=%h tick=%b err=%b busy=%b want all 0",
                         cyc, byte_dato, scan_done_tick, frame_err, busy);
            end
        end else begin
            tests++;
            if (scan_done_tick === 1'b1 && frame_err === 1'b1) begin
                fails++;
                $display("FAIL exclusive cyc=%0d tick and err both high", cyc);
            end
            if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
                ev = exp_q.pop_front();
                fails++;
                $display("FAIL missed_pulse cyc=%0d expected %s at cyc %0d, got none",
                         cyc, ev.is_err ? "err" : "tick", ev.cyc);
                if (!ev.is_err) model_byte = ev.data;
            end
            if (scan_done_tick === 1'b1 || frame_err === 1'b1) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_pulse cyc=%0d tick=%b err=%b want no pulse",
                             cyc, scan_done_tick, frame_err);
                end else begin
                    ev = exp_q.pop_front();
                    if (frame_err !== ev.is_err || ev.cyc != cyc) begin
                        fails++;
                        $display("FAIL pulse cyc=%0d got %s want %s at cyc %0d",
                                 cyc, frame_err ? "err" : "tick",
                                 ev.is_err ? "err" : "tick", ev.cyc);
                    end
                    if (!ev.is_err) model_byte = ev.data;
                end
            end
            tests++;
            if (byte_dato !== model_byte) begin
                fails++;
                $display("FAIL byte_dato cyc=%0d got %h want %h", cyc, byte_dato, model_byte);
            end
            exp_busy = (cyc >= bs) && (cyc <= be);
            tests++;
            if (busy !== exp_busy) begin
                fails++;
                $display("FAIL busy cyc=%0d got %b want %b", cyc, busy, exp_busy);
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_Nexys);
        #1;
    endtask

    task automatic check_lit(input string name, input logic [7:0] act, input logic [7:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s got %h want %h", name, act, want);
        end
    endtask

    // Sends bits[0..n-1]; when full, predicts the frame outcome at the stop edge.
    task automatic send_bits(input logic [10:0] bits, input int n, input int hp,
                             input bit full, input bit drop_en, input int glitch_bit,
                             output int last_k);
        bit active;
        bit ok;
        int k;
        active = rx_en;
        ok     = bits[10] && (^bits[9:1]);
        k      = 0;
        for (int i = 0; i < n; i++) begin
            ps2d = bits[i];
            if (glitch_bit == i) begin
                wait_cyc(hp / 3);
                ps2c = 1'b0;
                wait_cyc(4);
                ps2c = 1'b1;
                wait_cyc(hp - hp / 3 - 4);
            end else begin
                wait_cyc(hp);
            end
            ps2c = 1'b0;
            k    = cyc;
            if (active && i == 0) begin
                bs = k + LAT;
                be = 32'h7fffffff;
            end
            if (active && full && i == 10) begin
                exp_q.push_back('{!ok, k + LAT, bits[8:1]});
                be = k + LAT;
            end
            wait_cyc(hp);
            ps2c = 1'b1;
            if (drop_en && i == 0) rx_en = 1'b0;
        end
        last_k = k;
    endtask

    task automatic send_frame(input logic [7:0] data, input bit bad_par, input bit bad_stop,
                              input int hp, input bit drop_en, input int glitch_bit);
        logic [10:0] bits;
        int          k;
        bits = {~bad_stop, (~^data) ^ bad_par, data, 1'b0};
        send_bits(bits, 11, hp, 1'b1, drop_en, glitch_bit, k);
        ps2d = 1'b1;
        wait_cyc(hp);
        if (drop_en) rx_en = 1'b1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] bits;
        int          k;
        logic [7:0]  d;
        int          hp;
        bit          bp, bstop, dr;
        int          gl;

        wait_cyc(5);
        Reset = 1'b0;
        wait_cyc(5);
        check_lit("reset_byte", byte_dato, 8'h00);
        check_lit("reset_busy", {7'd0, busy}, 8'h00);

        // parity error right after reset: byte stays 0
        send_frame(8'h1C, 1'b1, 1'b0, 50, 1'b0, -1);
        check_lit("parity_err_keeps_byte", byte_dato, 8'h00);

        // plain valid frame
        send_frame(8'h1C, 1'b0, 1'b0, 50, 1'b0, -1);
        check_lit("valid_1C", byte_dato, 8'h1C);

        // break sequence
        send_frame(8'hF0, 1'b0, 1'b0, 40, 1'b0, -1);
        check_lit("break_F0", byte_dato, 8'hF0);
        send_frame(8'h1C, 1'b0, 1'b0, 40, 1'b0, -1);
        check_lit("break_1C", byte_dato, 8'h1C);

        // idle glitch, then a frame with a glitch in bit 3's high phase
        ps2c = 1'b0;
        wait_cyc(4);
        ps2c = 1'b1;
        wait_cyc(30);
        check_lit("idle_glitch_busy", {7'd0, busy}, 8'h00);
        send_frame(8'h5A, 1'b0, 1'b0, 30, 1'b0, 3);
        check_lit("glitch_5A", byte_dato, 8'h5A);

        // stall after start + 4 bits
        bits = {2'b11, 8'h29, 1'b0};
        send_bits(bits, 5, 30, 1'b0, 1'b0, -1, k);
        ps2d = 1'b1;
        be   = k + LAT + TO - 1;
        exp_q.push_back('{1'b1, k + LAT + TO, 8'h00});
        wait_cyc(TO + 50);
        check_lit("timeout_keeps_byte", byte_dato, 8'h5A);
        send_frame(8'h29, 1'b0, 1'b0, 30, 1'b0, -1);
        check_lit("after_timeout_29", byte_dato, 8'h29);

        // rx_en low: whole frame ignored
        rx_en = 1'b0;
        wait_cyc(2);
        send_frame(8'h77, 1'b0, 1'b0, 30, 1'b0, -1);
        rx_en = 1'b1;
        wait_cyc(5);
        check_lit("rx_en_off_ignored", byte_dato, 8'h29);

        // rx_en dropped after the start bit: frame still completes
        send_frame(8'h33, 1'b0, 1'b0, 30, 1'b1, -1);
        check_lit("rx_en_drop_33", byte_dato, 8'h33);

        // reset in the middle of a frame
        bits = {2'b11, 8'hA5, 1'b0};
        send_bits(bits, 4, 30, 1'b0, 1'b0, -1, k);
        Reset = 1'b1;
        bs    = 1;
        be    = 0;
        wait_cyc(3);
        Reset = 1'b0;
        ps2d  = 1'b1;
        wait_cyc(30);
        check_lit("mid_reset_byte", byte_dato, 8'h00);

        // random traffic
        for (int n = 0; n < 40; n++) begin
            d     = 8'($urandom_range(0, 255));
            hp    = $urandom_range(20, 40);
            bp    = ($urandom_range(0, 4) == 0);
            bstop = ($urandom_range(0, 9) == 0);
            dr    = ($urandom_range(0, 7) == 0);
            gl    = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 10) : -1;
            send_frame(d, bp, bstop, hp, dr, gl);
        end

        wait_cyc(20);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL pending_events got %0d outstanding want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
